// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared definitions for the LFSR pattern controller: run-state
//            encoding and the Fibonacci LFSR step function.
// Contents : IDLE/RUN/DONE state codes, state_e enum, lfsr_step().
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Widest LFSR the step helper supports; callers zero-extend into this.
  localparam int unsigned LFSR_WMAX = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

  // Pattern bit k (k = 1..n) lives at packed position [n-k], so bit 1 is the
  // MSB. A right shift in [1:n] terms is a numeric >> 1, and the feedback bit
  // enters at bit 1, i.e. packed position n-1. Bits at and above n must be 0.
  function automatic logic [LFSR_WMAX-1:0] lfsr_step(
    input logic [LFSR_WMAX-1:0] state,
    input logic [LFSR_WMAX-1:0] taps,
    input int unsigned          n
  );
    logic fb;
    fb = ^(state & taps);
    return (state >> 1) | (LFSR_WMAX'(fb) << (n - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core_ld.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core_ld
// Purpose  : Fibonacci LFSR state register with run-time synchronous load.
// Ports    : clk_i, reset_i  - clock, synchronous active-high reset (q -> 0)
//            ld_i, d_i       - load d_i into the register (wins over en_i)
//            en_i            - advance one LFSR step
//            q_o             - current state
//            nxt_o           - state after one step from q_o
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_core_ld
  import lfsr_pkg::*;
#(
  parameter int unsigned     N    = 3,
  parameter logic [N-1:0]    TAPS = 3'b011
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] nxt_o
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  assign nxt_o = N'(lfsr_step(LFSR_WMAX'(state_q), LFSR_WMAX'(TAPS), N));

  always_comb begin
    state_d = state_q;
    if (ld_i) begin
      state_d = d_i;
    end else if (en_i) begin
      state_d = nxt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pattern_ctrl
// Purpose  : Run controller for a Fibonacci LFSR pattern source. Loads a seed
//            on command and streams a programmable number of patterns over a
//            valid/ready interface, reporting done/abort/lock-up/wrap.
// Ports    : clk_i, reset_i          - clock, synchronous active-high reset
//            start_i, seed_i, count_i - command (sampled in IDLE only)
//            abort_i                  - stop current run (RUN only)
//            busy_o                   - high in RUN and DONE
//            out_valid_o/out_ready_i  - pattern handshake
//            out_data_o, pat_idx_o    - current pattern and its 0-based index
//            done_o                   - one-cycle end-of-command pulse
//            aborted_o, err_zero_seed_o - qualify done_o
//            wrapped_o                - sticky: sequence returned to the seed
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_pattern_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned  N    = 3,
  parameter logic [N-1:0] TAPS = 3'b011,
  parameter int unsigned  CW   = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [N-1:0]  seed_i,
  input  logic [CW-1:0] count_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_data_o,
  output logic [CW-1:0] pat_idx_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          err_zero_seed_o,
  output logic          wrapped_o
);

  state_e        state_q;
  logic [CW-1:0] remaining_q;
  logic [CW-1:0] idx_q;
  logic [N-1:0]  seed_q;
  logic          busy_q;
  logic          valid_q;
  logic          done_q;
  logic          aborted_q;
  logic          err_q;
  logic          wrapped_q;

  logic          lfsr_ld;
  logic          xfer;
  logic          last_xfer;
  logic [N-1:0]  lfsr_nxt;

  // Only an accepted, non-empty, non-zero-seed command seeds the LFSR.
  assign lfsr_ld   = (state_q == S_IDLE) && start_i && (seed_i != '0) && (count_i != '0);
  assign xfer      = (state_q == S_RUN) && valid_q && out_ready_i;
  assign last_xfer = xfer && (remaining_q == CW'(1));

  lfsr_core_ld #(
    .N    (N),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ld_i    (lfsr_ld),
    .en_i    (xfer),
    .d_i     (seed_i),
    .q_o     (out_data_o),
    .nxt_o   (lfsr_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            seed_q      <= seed_i;
            remaining_q <= count_i;
            idx_q       <= '0;
            wrapped_q   <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (seed_i == '0) begin
              // All-zero state locks the LFSR; reject even when count is 0.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (count_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              valid_q <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            idx_q       <= idx_q + CW'(1);
            remaining_q <= remaining_q - CW'(1);
            // Back at the seed with patterns still owed: the period repeats.
            if ((lfsr_nxt == seed_q) && (remaining_q != CW'(1))) begin
              wrapped_q <= 1'b1;
            end
          end
          // A final transfer wins over a coincident abort.
          if (last_xfer) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (abort_i) begin
            aborted_q <= 1'b1;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign out_valid_o     = valid_q;
  assign pat_idx_o       = idx_q;
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;
  assign err_zero_seed_o = err_q;
  assign wrapped_o       = wrapped_q;

endmodule
`default_nettype wire
